// File: rtl/mvu_pe_acc_ctrl.sv
// mvu_pe_acc_ctrl -- accumulation controller for one matrix-vector PE.
//
// Accepts SIMD vectors into a free-running adder tree, tracks them with a
// valid shift register matching the tree latency, and folds SF partial sums
// into one output neuron. Finished neurons go through a small
// first-word-fall-through FIFO. Input acceptance is gated by credits, so a
// started neuron always has a FIFO slot waiting for it.
//
// Optional feature: define MVU_PE_ACC_SAT_EN to saturate an overflowing sum
// instead of wrapping it. The ovf flag is the same in both builds.
//
// Ports:
//   clock    : rising-edge clock
//   reset    : asynchronous, active-high reset
//   s_valid  : vector presented to the adder tree this cycle
//   s_ready  : vector accepted (beat fires on s_valid && s_ready)
//   in_psum  : adder-tree partial sum, two's complement, TDst_I bits
//   m_valid  : out_acc holds a finished neuron
//   m_ready  : downstream accepts (pop on m_valid && m_ready)
//   out_acc  : accumulated dot product, two's complement, TDst_O bits
//   ovf      : sticky signed-overflow flag
module mvu_pe_acc_ctrl #(
   parameter int SF        = 4,
   parameter int ADD_LAT   = 4,
   parameter int TDst_I    = 6,
   parameter int TDst_O    = 10,
   parameter int OUT_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [TDst_I-1:0] in_psum,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [TDst_O-1:0] out_acc,
   output logic              ovf
);

   localparam int FW = (SF > 1) ? $clog2(SF) : 1;
   localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CW = $clog2(OUT_DEPTH + 1);
   localparam logic [FW-1:0] FOLD_LAST = FW'(SF - 1);
   localparam logic [PW-1:0] PTR_LAST  = PW'(OUT_DEPTH - 1);
   localparam logic [CW-1:0] DEPTH_C   = CW'(OUT_DEPTH);

   logic [ADD_LAT-1:0] vld_pipe;
   logic [FW-1:0]      in_fold, out_fold;
   logic [CW-1:0]      credits, count;
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [TDst_O-1:0]  acc;
   logic [TDst_O-1:0]  mem [OUT_DEPTH];

   logic              fire, take, pop, cap, wr, first, add_ovf;
   logic [TDst_O-1:0] ext, sum_raw, sum_sel, nxt;

   assign fire = s_valid && s_ready;
   assign take = fire && (in_fold == '0);   // first beat of a neuron claims a slot
   assign pop  = m_valid && m_ready;
   assign cap  = vld_pipe[ADD_LAT-1];       // psum of an accepted beat is on in_psum
   assign wr   = cap && (out_fold == FOLD_LAST);

   // A neuron in progress already owns its slot, so it never stalls mid-fold.
   assign s_ready = !reset && ((in_fold != '0) || (credits != '0));
   assign m_valid = (count != '0);
   assign out_acc = m_valid ? mem[rd_ptr] : '0;

   assign ext     = TDst_O'($signed(in_psum));
   assign sum_raw = acc + ext;
   assign first   = (out_fold == '0);
   // Same-sign operands producing a different-sign result.
   assign add_ovf = (acc[TDst_O-1] == ext[TDst_O-1]) &&
                    (sum_raw[TDst_O-1] != acc[TDst_O-1]);

`ifdef MVU_PE_ACC_SAT_EN
   localparam logic [TDst_O-1:0] ACC_MAX = {1'b0, {(TDst_O-1){1'b1}}};
   localparam logic [TDst_O-1:0] ACC_MIN = {1'b1, {(TDst_O-1){1'b0}}};
   assign sum_sel = add_ovf ? (acc[TDst_O-1] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
   assign sum_sel = sum_raw;
`endif

   // First fold loads rather than adds; SF=1 therefore passes psums through.
   assign nxt = first ? ext : sum_sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_pipe <= '0;
         in_fold  <= '0;
         out_fold <= '0;
         acc      <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         credits  <= DEPTH_C;
         ovf      <= 1'b0;
      end else begin
         vld_pipe[0] <= fire;
         for (int i = 1; i < ADD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];

         if (fire) in_fold <= (in_fold == FOLD_LAST) ? '0 : in_fold + 1'b1;

         // Take and return in the same cycle cancel out.
         credits <= credits - CW'(take) + CW'(pop);
         count   <= count + CW'(wr) - CW'(pop);

         if (pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         if (wr)  wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

         if (cap) begin
            acc      <= nxt;
            out_fold <= (out_fold == FOLD_LAST) ? '0 : out_fold + 1'b1;
            if (!first && add_ovf) ovf <= 1'b1;
         end
      end
   end

   // Storage needs no reset: contents are only visible while count != 0.
   always_ff @(posedge clock) begin
      if (wr) mem[wr_ptr] <= nxt;
   end

endmodule

// File: tb/tb_mvu_pe_acc_ctrl.sv
// Bench for mvu_pe_acc_ctrl: three instances (default, SF=2/TDst_O=6, SF=3).
// The bench models the adder tree as an ADD_LAT-deep data delay and drives
// random junk on in_psum whenever no accepted beat is due.
module tb_mvu_pe_acc_ctrl;
   localparam int AL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] sv = '0;
   logic [2:0] mr = '0;
   logic [2:0] sr, mv, ov;
   logic [5:0] sd [3];
   logic [5:0] ip [3];
   logic [5:0] pd [3][AL];
   logic       pv [3][AL];
   logic [5:0] junk;
   logic [9:0] acc0, acc2;
   logic [5:0] acc1;
   int         nfire [3];

   int n_chk = 0;
   int n_fail = 0;
   int last_fire = 0;

   // Adder-tree model: accepted vector data reappears ADD_LAT cycles later.
   always @(posedge clk) begin
      junk <= 6'($urandom);
      for (int g = 0; g < 3; g++) begin
         pv[g][0] <= sv[g] && sr[g];
         pd[g][0] <= sd[g];
         for (int i = 1; i < AL; i++) begin
            pv[g][i] <= pv[g][i-1];
            pd[g][i] <= pd[g][i-1];
         end
         if (sv[g] && sr[g]) nfire[g] <= nfire[g] + 1;
      end
   end

   always_comb begin
      for (int g = 0; g < 3; g++) ip[g] = pv[g][AL-1] ? pd[g][AL-1] : junk;
   end

   mvu_pe_acc_ctrl u0 (
      .clock(clk), .reset(rst), .s_valid(sv[0]), .s_ready(sr[0]), .in_psum(ip[0]),
      .m_valid(mv[0]), .m_ready(mr[0]), .out_acc(acc0), .ovf(ov[0]));

   mvu_pe_acc_ctrl #(.SF(2), .TDst_O(6)) u1 (
      .clock(clk), .reset(rst), .s_valid(sv[1]), .s_ready(sr[1]), .in_psum(ip[1]),
      .m_valid(mv[1]), .m_ready(mr[1]), .out_acc(acc1), .ovf(ov[1]));

   mvu_pe_acc_ctrl #(.SF(3)) u2 (
      .clock(clk), .reset(rst), .s_valid(sv[2]), .s_ready(sr[2]), .in_psum(ip[2]),
      .m_valid(mv[2]), .m_ready(mr[2]), .out_acc(acc2), .ovf(ov[2]));

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      sv = '0; mr = '0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Present one vector from a negedge and wait until it is accepted.
   task automatic beat(input int g, input logic [5:0] v);
      int t = 0;
      @(negedge clk);
      sd[g] = v; sv[g] = 1'b1;
      while (!sr[g] && t < 50) begin @(negedge clk); t++; end
      if (!sr[g]) chk("beat_timeout", 0, 1);
      last_fire = cyc;
      @(posedge clk);
   endtask

   task automatic wait_out(input int g, output int lat);
      int t = 0;
      @(negedge clk);
      sv[g] = 1'b0;
      while (!mv[g] && t < 40) begin @(negedge clk); t++; end
      if (!mv[g]) chk("m_valid_timeout", 0, 1);
      lat = cyc - last_fire;
   endtask

   typedef struct {
      logic [3:0][5:0] ps;
      logic [9:0]      exp;
   } vec_t;
   vec_t tbl [5];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat, n, f0, outstanding, s;
      int exp_q [$];
      int part [$];

      tbl[0].ps = {6'd4, 6'd3, 6'd2, 6'd1};             tbl[0].exp = 10'd10;
      tbl[1].ps = {6'h3F, 6'h3F, 6'h3F, 6'h3F};         tbl[1].exp = 10'h3FC;
      tbl[2].ps = {6'd31, 6'd31, 6'd31, 6'd31};         tbl[2].exp = 10'd124;
      tbl[3].ps = {6'h20, 6'h20, 6'h20, 6'h20};         tbl[3].exp = 10'h380;
      tbl[4].ps = {6'h3F, 6'd5, 6'h20, 6'd31};          tbl[4].exp = 10'd3;
      for (int g = 0; g < 3; g++) sd[g] = '0;

      // Reset state.
      repeat (2) @(negedge clk);
      chk("rst_s_ready", sr[0], 0);
      chk("rst_m_valid", mv[0], 0);
      chk("rst_out_acc", acc0, 0);
      chk("rst_ovf", ov[0], 0);
      rst = 1'b0;
      #1 chk("s_ready_after_release", sr[0], 1);

      // Table of single neurons, m_ready held high.
      for (int e = 0; e < 5; e++) begin
         do_reset();
         mr[0] = 1'b1;
         for (int i = 0; i < 4; i++) beat(0, tbl[e].ps[i]);
         wait_out(0, lat);
         chk($sformatf("tbl%0d_latency", e), lat, AL + 1);
         chk($sformatf("tbl%0d_out_acc", e), acc0, tbl[e].exp);
         chk($sformatf("tbl%0d_ovf", e), ov[0], 0);
         @(negedge clk);
         chk($sformatf("tbl%0d_single_pulse", e), mv[0], 0);
      end

      // Back-pressure: two neurons fill the credits, then acceptance stops.
      do_reset();
      f0 = nfire[0];
      @(negedge clk);
      sd[0] = 6'd1; sv[0] = 1'b1;
      repeat (20) @(negedge clk);
      chk("bp_beats_accepted", nfire[0] - f0, 8);
      chk("bp_s_ready_low", sr[0], 0);
      chk("bp_m_valid", mv[0], 1);
      chk("bp_first_out", acc0, 4);
      sv[0] = 1'b0; mr[0] = 1'b1;
      @(negedge clk);
      mr[0] = 1'b0;
      chk("bp_s_ready_restored", sr[0], 1);
      chk("bp_second_out", acc0, 4);
      chk("bp_second_valid", mv[0], 1);

      // Reset in the middle of a neuron with beats in flight.
      do_reset();
      mr[0] = 1'b1;
      beat(0, 6'd5);
      beat(0, 6'd5);
      @(negedge clk);
      sv[0] = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("midrst_s_ready", sr[0], 0);
      chk("midrst_m_valid", mv[0], 0);
      chk("midrst_out_acc", acc0, 0);
      @(negedge clk);
      rst = 1'b0;
      mr[0] = 1'b1;
      for (int i = 0; i < 4; i++) beat(0, 6'd5);
      wait_out(0, lat);
      chk("midrst_out_acc_after", acc0, 20);
      n = 0;
      repeat (15) begin
         if (mv[0]) n++;
         @(negedge clk);
      end
      chk("midrst_output_count", n, 1);

      // Narrow accumulator: no overflow, then overflow.
      do_reset();
      mr[1] = 1'b1;
      beat(1, 6'd10);
      beat(1, 6'h3D);
      wait_out(1, lat);
      chk("narrow_out_acc", acc1, 7);
      chk("narrow_ovf_clear", ov[1], 0);
      beat(1, 6'd31);
      beat(1, 6'd31);
      wait_out(1, lat);
`ifdef MVU_PE_ACC_SAT_EN
      chk("narrow_ovf_sum", acc1, 31);
`else
      chk("narrow_ovf_sum", acc1, 6'h3E);
`endif
      chk("narrow_ovf_set", ov[1], 1);
      repeat (3) @(negedge clk);
      chk("narrow_ovf_sticky", ov[1], 1);

      // Random traffic on SF=3 against a queue-based reference.
      do_reset();
      outstanding = 0;
      for (int c = 0; c < 10000; c++) begin
         sv[2] = ($urandom_range(0, 3) != 0);
         mr[2] = ($urandom_range(0, 2) != 0);
         sd[2] = 6'($urandom);
         if (mv[2] && mr[2]) begin
            if (exp_q.size() == 0) chk("rnd_spurious_output", 1, 0);
            else chk("rnd_out_acc", acc2, exp_q.pop_front());
            outstanding--;
         end
         if (sv[2] && sr[2]) begin
            if (part.size() == 0) begin
               outstanding++;
               chk("rnd_capacity", outstanding <= 2, 1);
            end
            part.push_back(int'($signed(sd[2])));
            if (part.size() == 3) begin
               s = part[0] + part[1] + part[2];
               exp_q.push_back(s & 1023);
               part.delete();
            end
         end
         @(negedge clk);
      end
      sv[2] = 1'b0; mr[2] = 1'b1;
      repeat (40) begin
         if (mv[2]) begin
            if (exp_q.size() == 0) chk("rnd_spurious_output", 1, 0);
            else chk("rnd_out_acc", acc2, exp_q.pop_front());
         end
         @(negedge clk);
      end
      chk("rnd_all_drained", exp_q.size(), 0);
      chk("rnd_ovf", ov[2], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mvu_pe_acc_ctrl.md
MVU_PE_ACC_CTRL -- requirements
Module: mvu_pe_acc_ctrl

Interface
REQ-001 SHALL have parameter SF, default 4: synapse-fold beats (adder-tree partial sums) accumulated per output neuron; SF>=1.
REQ-002 SHALL have parameter ADD_LAT, default 4: fixed adder-tree latency, beat in to partial sum out, in cycles; ADD_LAT>=1.
REQ-003 SHALL have parameter TDst_I, default 6: partial-sum width.
REQ-004 SHALL have parameter TDst_O, default 10: accumulator/output width; TDst_O>=TDst_I.
REQ-005 SHALL have parameter OUT_DEPTH, default 2: output buffer depth in neurons; OUT_DEPTH>=1.
REQ-006 SHALL have port clock, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port s_valid, input, 1: SIMD vector presented to the free-running adder tree this cycle.
REQ-009 SHALL have port s_ready, output, 1: controller accepts the vector; beat fires on s_valid&&s_ready.
REQ-010 SHALL have port in_psum, input, TDst_I: adder-tree output, two's complement.
REQ-011 SHALL have port m_valid, output, 1: out_acc holds a finished neuron.
REQ-012 SHALL have port m_ready, input, 1: downstream accepts; pop on m_valid&&m_ready.
REQ-013 SHALL have port out_acc, output, TDst_O: accumulated dot product, two's complement.
REQ-014 SHALL have port ovf, output, 1: sticky flag, set on any signed accumulator overflow.

Function
REQ-015 SHALL track fired beats through an ADD_LAT-deep valid shift register; in_psum is captured only on the cycle its tap is 1.
REQ-016 SHALL keep an input fold counter 0..SF-1, advanced per fired beat, wrapping to 0 after SF-1.
REQ-017 SHALL keep a credit counter, initialised to OUT_DEPTH, 0..OUT_DEPTH inclusive; one credit is consumed when a beat fires with input fold count 0, one is returned per pop.
REQ-018 SHALL drive s_ready = (input fold count != 0) || (credits > 0); a neuron once started is never stalled.
REQ-019 SHALL sign-extend in_psum to TDst_O and add it to the accumulator; on output fold count 0, the accumulator is loaded with the extended value instead of added to.
REQ-020 SHALL, on the SF-th captured psum, write the final sum into the output FIFO and clear the output fold count; SF=1 passes each psum straight through.
REQ-021 SHALL hold out_acc stable and m_valid high until the pop; first-word-fall-through, minimum latency fire-to-m_valid = ADD_LAT+1 cycles for the last beat.
REQ-022 SHALL handle same-cycle pop and FIFO write, and same-cycle credit take and return (net credit unchanged), without loss.
REQ-023 SHALL never overflow the FIFO; credit accounting guarantees capacity by construction.
REQ-024 SHALL set ovf when operands share a sign and the result sign differs; ovf clears only on reset.

Reset
REQ-025 SHALL, on reset asserted, asynchronously clear valid shift register, both fold counters, accumulator, FIFO pointers/count and ovf; credits = OUT_DEPTH.
REQ-026 SHALL hold s_ready=0, m_valid=0, out_acc=0 and ovf=0 while reset is high; s_ready rises the first cycle after release.
REQ-027 SHALL discard in-flight beats and partial neurons on reset mid-operation; no stale output after release.

Configuration
REQ-028 SHALL, with MVU_PE_ACC_SAT_EN defined, clamp an overflowing sum to +(2^(TDst_O-1)-1) or -2^(TDst_O-1) by operand sign; without it, sums wrap modulo 2^TDst_O; ovf behaves identically in both builds.

Verification (defaults unless noted)
REQ-029 SHALL cover: 4 beats, psum 1,2,3,4, m_ready=1 -> one m_valid pulse, out_acc=10, ADD_LAT+1 cycles after last fire.
REQ-030 SHALL cover: psum 6'h3F x4 -> out_acc=-4 (10'h3FC), ovf=0.
REQ-031 SHALL cover: m_ready=0, s_valid=1 continuous -> exactly 8 beats accepted (2 neurons), then s_ready=0 at fold 0; one pop restores s_ready next cycle.
REQ-032 SHALL cover: TDst_O=6, psum 31,31 with SF=2 -> ovf=1; out_acc=31 with MVU_PE_ACC_SAT_EN, -2 without.
REQ-033 SHALL cover: reset asserted after 2 of 4 beats -> outputs clear at once; after release, 4 beats of 5 -> out_acc=20 only.
REQ-034 SHALL cover: random s_valid/m_ready, 10000 cycles, SF=3 -> every output equals the reference sum of its 3 psums, in order, with no FIFO overflow.
